load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// In-order 16-entry load/store queue with a fixed-latency word memory and one access in flight.
// Optional: define LSU_STORE_FWD_EN to let a load matching the last completed store finish in one cycle.
module load_store_unit #(
    parameter int MEM_SIZE_BYTES = 64,
    parameter int WRITE_LATENCY  = 10,
    parameter int READ_LATENCY   = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_store_enable,
    input  logic [1:0]  instruction_type,
    input  logic [5:0]  phys_rd,
    input  logic [5:0]  rob_entry,
    input  logic        load_store_enable_funct0,
    input  logic [31:0] address_funct0,
    input  logic [31:0] value_funct0,
    input  logic [5:0]  ROB_entry_num_funct0,
    input  logic        load_store_enable_funct1,
    input  logic [31:0] address_funct1,
    input  logic [31:0] value_funct1,
    input  logic [5:0]  ROB_entry_num_funct1,
    input  logic        load_store_enable_funct2,
    input  logic [31:0] address_funct2,
    input  logic [31:0] value_funct2,
    input  logic [5:0]  ROB_entry_num_funct2,
    output logic        fwd_enable,
    output logic [5:0]  fwd_phys_rd,
    output logic [31:0] fwd_value,
    output logic        enable_ROB,
    output logic [31:0] value
);
    localparam int MEM_WORDS = MEM_SIZE_BYTES / 4;
    localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               issue, complete;

    logic               q_valid [16];
    logic               q_store [16];
    logic [5:0]         q_phys  [16];
    logic [5:0]         q_rob   [16];
    logic               q_ready [16];
    logic [IDX_W-1:0]   q_idx   [16];
    logic [31:0]        q_data  [16];
    logic [3:0]         head, tail;
    logic [4:0]         count;

    logic [31:0]        mem [MEM_WORDS];

    logic               iss_store;
    logic [IDX_W-1:0]   iss_idx;
    logic [31:0]        iss_data;
    logic [5:0]         iss_phys;

    logic               head_ready, head_fwd_hit, alloc, pop, type_ok;
    logic [31:0]        load_data;
    logic [IDX_W-1:0]   idx0, idx1, idx2;
    logic               unused_addr_bits;

    // Only the word-index bits of an address matter; the rest wrap away.
    assign idx0 = address_funct0[IDX_W+1:2];
    assign idx1 = address_funct1[IDX_W+1:2];
    assign idx2 = address_funct2[IDX_W+1:2];
    assign unused_addr_bits = ^{address_funct0[31:IDX_W+2], address_funct0[1:0],
                                address_funct1[31:IDX_W+2], address_funct1[1:0],
                                address_funct2[31:IDX_W+2], address_funct2[1:0]};

    assign type_ok    = (instruction_type == 2'b01) || (instruction_type == 2'b10);
    assign head_ready = q_valid[head] && q_ready[head];
    assign pop        = complete;
    assign alloc      = load_store_enable && type_ok && ((count != 5'd16) || pop);

`ifdef LSU_STORE_FWD_EN
    logic               last_valid;
    logic [IDX_W-1:0]   last_idx;
    logic [31:0]        last_data;
    logic               iss_fwd;

    assign head_fwd_hit = last_valid && (last_idx == q_idx[head]);
    assign load_data    = iss_fwd ? last_data : mem[iss_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_valid <= 1'b0;
            last_idx   <= '0;
            last_data  <= '0;
            iss_fwd    <= 1'b0;
        end else begin
            if (issue)
                iss_fwd <= head_fwd_hit;
            if (complete && iss_store) begin
                last_valid <= 1'b1;
                last_idx   <= iss_idx;
                last_data  <= iss_data;
            end
        end
    end
`else
    assign head_fwd_hit = 1'b0;
    assign load_data    = mem[iss_idx];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter is preloaded with latency-1 so completion lands exactly latency edges after issue.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (head_ready) begin
                    issue      = 1'b1;
                    state_next = BUSY;
                    if (q_store[head])
                        cnt_next = CNT_W'(WRITE_LATENCY - 1);
                    else if (head_fwd_hit)
                        cnt_next = '0;
                    else
                        cnt_next = CNT_W'(READ_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                q_valid[i] <= 1'b0;
                q_store[i] <= 1'b0;
                q_phys[i]  <= '0;
                q_rob[i]   <= '0;
                q_ready[i] <= 1'b0;
                q_idx[i]   <= '0;
                q_data[i]  <= '0;
            end
            for (int w = 0; w < MEM_WORDS; w++)
                mem[w] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            iss_store   <= 1'b0;
            iss_idx     <= '0;
            iss_data    <= '0;
            iss_phys    <= '0;
            enable_ROB  <= 1'b0;
            fwd_enable  <= 1'b0;
            fwd_phys_rd <= '0;
            fwd_value   <= '0;
            value       <= '0;
        end else begin
            enable_ROB <= 1'b0;
            fwd_enable <= 1'b0;

            // Later ports are applied last so port 2 wins over 1, and 1 over 0.
            for (int i = 0; i < 16; i++) begin
                if (q_valid[i]) begin
                    if (load_store_enable_funct0 && (q_rob[i] == ROB_entry_num_funct0)) begin
                        q_idx[i]   <= idx0;
                        q_data[i]  <= value_funct0;
                        q_ready[i] <= 1'b1;
                    end
                    if (load_store_enable_funct1 && (q_rob[i] == ROB_entry_num_funct1)) begin
                        q_idx[i]   <= idx1;
                        q_data[i]  <= value_funct1;
                        q_ready[i] <= 1'b1;
                    end
                    if (load_store_enable_funct2 && (q_rob[i] == ROB_entry_num_funct2)) begin
                        q_idx[i]   <= idx2;
                        q_data[i]  <= value_funct2;
                        q_ready[i] <= 1'b1;
                    end
                end
            end

            if (issue) begin
                iss_store <= q_store[head];
                iss_idx   <= q_idx[head];
                iss_data  <= q_data[head];
                iss_phys  <= q_phys[head];
            end

            if (complete) begin
                enable_ROB <= 1'b1;
                if (iss_store) begin
                    mem[iss_idx] <= iss_data;
                    value        <= iss_data;
                end else begin
                    value       <= load_data;
                    fwd_enable  <= 1'b1;
                    fwd_phys_rd <= iss_phys;
                    fwd_value   <= load_data;
                end
                q_valid[head] <= 1'b0;
                head          <= head + 4'd1;
            end

            // Allocation comes after the pop so a full queue can refill the slot being freed.
            if (alloc) begin
                q_valid[tail] <= 1'b1;
                q_store[tail] <= (instruction_type == 2'b10);
                q_phys[tail]  <= phys_rd;
                q_rob[tail]   <= rob_entry;
                q_ready[tail] <= 1'b0;
                q_idx[tail]   <= '0;
                q_data[tail]  <= '0;
                tail          <= tail + 4'd1;
            end

            count <= count + 5'(alloc) - 5'(pop);
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at address resolution
// and matched against enable_ROB/fwd pulses, including cycle of arrival.
module tb_load_store_unit;
    localparam int RL = 10;
    localparam int WL = 10;
`ifdef LSU_STORE_FWD_EN
    localparam int FL = 1;
`else
    localparam int FL = RL;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_store_enable;
    logic [1:0]  instruction_type;
    logic [5:0]  phys_rd;
    logic [5:0]  rob_entry;
    logic        en0, en1, en2;
    logic [31:0] addr0, addr1, addr2;
    logic [31:0] val0, val1, val2;
    logic [5:0]  tag0, tag1, tag2;
    logic        fwd_enable;
    logic [5:0]  fwd_phys_rd;
    logic [31:0] fwd_value;
    logic        enable_ROB;
    logic [31:0] value;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE_BYTES(64), .WRITE_LATENCY(WL), .READ_LATENCY(RL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .load_store_enable(load_store_enable),
        .instruction_type(instruction_type),
        .phys_rd(phys_rd),
        .rob_entry(rob_entry),
        .load_store_enable_funct0(en0),
        .address_funct0(addr0),
        .value_funct0(val0),
        .ROB_entry_num_funct0(tag0),
        .load_store_enable_funct1(en1),
        .address_funct1(addr1),
        .value_funct1(val1),
        .ROB_entry_num_funct1(tag1),
        .load_store_enable_funct2(en2),
        .address_funct2(addr2),
        .value_funct2(val2),
        .ROB_entry_num_funct2(tag2),
        .fwd_enable(fwd_enable),
        .fwd_phys_rd(fwd_phys_rd),
        .fwd_value(fwd_value),
        .enable_ROB(enable_ROB),
        .value(value)
    );

    typedef struct {
        logic        is_load;
        logic [5:0]  phys;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   passed = 0;
    int   failed = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(logic is_load, logic [5:0] phys, logic [31:0] val, int c);
        exp_t e;
        e.is_load = is_load;
        e.phys    = phys;
        e.val     = val;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    // Pulses are sampled on the falling edge, where cyc equals the number of rising edges so far.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && fwd_enable && !enable_ROB)
            check_output("fwd_without_rob", 32'd1, 32'd0);
        if (enable_ROB) begin
            if (sb.size() == 0) begin
                check_output("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output("pulse_cycle", cyc, e.cyc);
                check_output("rob_value", value, e.val);
                check_output("fwd_enable", {31'd0, fwd_enable}, {31'd0, e.is_load});
                if (e.is_load) begin
                    check_output("fwd_phys_rd", {26'd0, fwd_phys_rd}, {26'd0, e.phys});
                    check_output("fwd_value", fwd_value, e.val);
                end
            end
        end
    end

    task automatic dispatch(logic [1:0] t, logic [5:0] tag, logic [5:0] pr);
        @(negedge clk);
        load_store_enable = 1'b1;
        instruction_type  = t;
        rob_entry         = tag;
        phys_rd           = pr;
        @(negedge clk);
        load_store_enable = 1'b0;
        instruction_type  = 2'b00;
    endtask

    task automatic clear_funct();
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        val0 = '0;  val1 = '0;  val2 = '0;
        tag0 = '0;  tag1 = '0;  tag2 = '0;
    endtask

    task automatic apply_stimulus(int port, logic [31:0] a, logic [31:0] v, logic [5:0] tag,
                                  output int edge_num);
        @(negedge clk);
        case (port)
            0: begin en0 = 1'b1; addr0 = a; val0 = v; tag0 = tag; end
            1: begin en1 = 1'b1; addr1 = a; val1 = v; tag1 = tag; end
            default: begin en2 = 1'b1; addr2 = a; val2 = v; tag2 = tag; end
        endcase
        edge_num = cyc + 1;
        @(negedge clk);
        clear_funct();
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(string phase);
        check_output({phase, "_enable_ROB"}, {31'd0, enable_ROB}, 32'd0);
        check_output({phase, "_fwd_enable"}, {31'd0, fwd_enable}, 32'd0);
        check_output({phase, "_value"}, value, 32'd0);
        check_output({phase, "_fwd_phys_rd"}, {26'd0, fwd_phys_rd}, 32'd0);
        check_output({phase, "_fwd_value"}, fwd_value, 32'd0);
    endtask

    initial begin
        int f, f0, fs, fl, cs;
        reset_n           = 1'b0;
        load_store_enable = 1'b0;
        instruction_type  = 2'b00;
        phys_rd           = '0;
        rob_entry         = '0;
        clear_funct();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        $display("[TB] unmatched funct write and unallocated types");
        apply_stimulus(0, 32'h4, 32'hAAAABBBB, 6'd1, f);
        dispatch(2'b00, 6'd50, 6'd1);
        dispatch(2'b11, 6'd51, 6'd1);
        apply_stimulus(0, 32'h4, 32'h11111111, 6'd50, f);
        apply_stimulus(1, 32'h4, 32'h22222222, 6'd51, f);
        repeat (20) @(negedge clk);
        check_output("idle_value", value, 32'd0);

        dispatch(2'b01, 6'd10, 6'd1);
        apply_stimulus(0, 32'h4, 32'hFFFFFFFF, 6'd10, f);
        expect_pulse(1'b1, 6'd1, 32'h0, f + 1 + RL);
        wait_drain(40);

        $display("[TB] store then load at 0x8");
        dispatch(2'b10, 6'd2, 6'd0);
        apply_stimulus(1, 32'h8, 32'hCCCCDDDD, 6'd2, f);
        expect_pulse(1'b0, 6'd0, 32'hCCCCDDDD, f + 1 + WL);
        wait_drain(40);
        dispatch(2'b01, 6'd3, 6'd5);
        apply_stimulus(2, 32'h8, 32'h0, 6'd3, f);
        expect_pulse(1'b1, 6'd5, 32'hCCCCDDDD, f + 1 + FL);
        wait_drain(40);

        $display("[TB] address wrap-around");
        dispatch(2'b10, 6'd4, 6'd0);
        apply_stimulus(0, 32'h4, 32'h12345678, 6'd4, f);
        expect_pulse(1'b0, 6'd0, 32'h12345678, f + 1 + WL);
        wait_drain(40);
        dispatch(2'b01, 6'd5, 6'd7);
        apply_stimulus(1, 32'h44, 32'h0, 6'd5, f);
        expect_pulse(1'b1, 6'd7, 32'h12345678, f + 1 + FL);
        wait_drain(40);

        $display("[TB] same-cycle port priority");
        dispatch(2'b10, 6'd6, 6'd0);
        @(negedge clk);
        en0 = 1'b1; addr0 = 32'h30; val0 = 32'h00000000; tag0 = 6'd6;
        en1 = 1'b1; addr1 = 32'h34; val1 = 32'h11111111; tag1 = 6'd6;
        en2 = 1'b1; addr2 = 32'h10; val2 = 32'h22222222; tag2 = 6'd6;
        f = cyc + 1;
        @(negedge clk);
        clear_funct();
        expect_pulse(1'b0, 6'd0, 32'h22222222, f + 1 + WL);
        wait_drain(40);
        dispatch(2'b01, 6'd11, 6'd12);
        apply_stimulus(0, 32'h10, 32'h0, 6'd11, f);
        expect_pulse(1'b1, 6'd12, 32'h22222222, f + 1 + FL);
        wait_drain(40);
        dispatch(2'b01, 6'd12, 6'd13);
        apply_stimulus(0, 32'h30, 32'h0, 6'd12, f);
        expect_pulse(1'b1, 6'd13, 32'h0, f + 1 + RL);
        wait_drain(40);

        $display("[TB] program order with younger load resolved first");
        dispatch(2'b10, 6'd7, 6'd0);
        dispatch(2'b01, 6'd8, 6'd9);
        apply_stimulus(0, 32'h20, 32'h0, 6'd8, fl);
        apply_stimulus(1, 32'h20, 32'h77777777, 6'd7, fs);
        cs = fs + 1 + WL;
        expect_pulse(1'b0, 6'd0, 32'h77777777, cs);
        expect_pulse(1'b1, 6'd9, 32'h77777777, cs + 1 + FL);
        wait_drain(60);

        $display("[TB] queue overflow");
        for (int k = 0; k < 17; k++)
            dispatch(2'b01, 6'(20 + k), 6'(k));
        apply_stimulus(2, 32'h8, 32'h0, 6'd36, f);
        f0 = 0;
        for (int k = 0; k < 16; k++) begin
            apply_stimulus(k % 3, 32'h8, 32'h0, 6'(20 + k), f);
            if (k == 0) f0 = f;
            expect_pulse(1'b1, 6'(k), 32'hCCCCDDDD, f0 + 1 + RL + k * (RL + 1));
        end
        wait_drain(400);
        repeat (30) @(negedge clk);

        $display("[TB] reset during store");
        dispatch(2'b10, 6'd40, 6'd0);
        apply_stimulus(0, 32'h30, 32'hDEADBEEF, 6'd40, f);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        dispatch(2'b01, 6'd41, 6'd2);
        apply_stimulus(1, 32'h30, 32'h0, 6'd41, f);
        expect_pulse(1'b1, 6'd2, 32'h0, f + 1 + RL);
        wait_drain(40);
        dispatch(2'b01, 6'd42, 6'd3);
        apply_stimulus(2, 32'h8, 32'h0, 6'd42, f);
        expect_pulse(1'b1, 6'd3, 32'h0, f + 1 + RL);
        wait_drain(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
